// File: rtl/lsu_pkg.sv
// Shared encodings and request-decode helpers for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD0  = 3'd1,
      RD1  = 3'd2,
      WR0  = 3'd3,
      WR1  = 3'd4,
      DONE = 3'd5
   } lsu_state_t;

   function automatic logic [2:0] size_of(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: size_of = 3'd1;
         F3_H, F3_HU: size_of = 3'd2;
         default:     size_of = 3'd4;
      endcase
   endfunction

   function automatic logic spans(input logic [1:0] off, input logic [2:0] size);
      spans = ({2'b00, off} + {1'b0, size}) > 4'd4;
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane merge of store data into a two-word window and load extract/extend.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [63:0] words_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  size_i,
   input  logic        sext_i,
   input  logic [31:0] wdata_i,
   output logic [63:0] merged_o,
   output logic [31:0] rdata_o
);

   logic        [31:0] raw;
   logic signed [7:0]  raw_b;
   logic signed [15:0] raw_h;
   logic signed [31:0] ext_b;
   logic signed [31:0] ext_h;

   always_comb begin
      merged_o = words_i;
      for (int k = 0; k < 4; k++) begin
         if (k < int'(size_i)) begin
            merged_o[(int'(off_i) + k) * 8 +: 8] = wdata_i[k * 8 +: 8];
         end
      end
   end

   always_comb begin
      raw   = 32'(words_i >> {off_i, 3'b000});
      raw_b = raw[7:0];
      raw_h = raw[15:0];
      ext_b = 32'(raw_b);
      ext_h = 32'(raw_h);
      case (size_i)
         3'd1:    rdata_o = sext_i ? ext_b : {24'd0, raw[7:0]};
         3'd2:    rdata_o = sext_i ? ext_h : {16'd0, raw[15:0]};
         default: rdata_o = raw;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Sequential load/store unit: turns byte/half/word requests into word-aligned
// memory accesses, with read-modify-write for partial stores and split straddles.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ALLOW_MISALIGNED = 1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        Req,
   input  logic [31:0] Address,
   input  logic [31:0] DataWr,
   input  logic        DMWr,
   input  logic [2:0]  DMCtrl,
   output logic [31:0] DataRd,
   output logic        Busy,
   output logic        Done,
   output logic        Error,
   output logic [31:0] MemAddress,
   output logic [31:0] MemDataWr,
   output logic        MemDMWr,
   output logic [2:0]  MemDMCtrl,
   input  logic [31:0] MemDataRd
);

   lsu_state_t  state_q, state_d;
   logic [31:0] addr_q, wdata_q, b0_q, b1_q, datard_q;
   logic [2:0]  ctrl_q;
   logic        wr_q, err_q;

   logic        in_span, in_illegal, in_full_sw;
   logic [2:0]  size_q;
   logic        span_q, sext_q;
   logic [31:0] w0, w1, lane_rdata;
   logic [63:0] lane_words, merged;

   assign in_span    = spans(Address[1:0], size_of(DMCtrl));
   assign in_illegal = (DMCtrl == 3'b011) || (DMCtrl == 3'b110) || (DMCtrl == 3'b111)
                     || (DMWr && ((DMCtrl == F3_BU) || (DMCtrl == F3_HU)))
                     || ((ALLOW_MISALIGNED == 0) && in_span);
   assign in_full_sw = DMWr && (DMCtrl == F3_W) && (Address[1:0] == 2'b00);

   assign size_q = size_of(ctrl_q);
   assign span_q = spans(addr_q[1:0], size_q);
   assign sext_q = (ctrl_q == F3_B) || (ctrl_q == F3_H);
   assign w0     = {addr_q[31:2], 2'b00};
   assign w1     = w0 + 32'd4;

   // The word being read this cycle bypasses its buffer so the load result is ready at DONE.
   assign lane_words = {(state_q == RD1) ? MemDataRd : b1_q,
                        (state_q == RD0) ? MemDataRd : b0_q};

   lsu_lane u_lane (
      .words_i  (lane_words),
      .off_i    (addr_q[1:0]),
      .size_i   (size_q),
      .sext_i   (sext_q),
      .wdata_i  (wdata_q),
      .merged_o (merged),
      .rdata_o  (lane_rdata)
   );

   always_comb begin
      state_d    = state_q;
      MemAddress = '0;
      MemDataWr  = '0;
      MemDMWr    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Req) begin
               if (in_illegal)      state_d = DONE;
               else if (in_full_sw) state_d = WR0;
               else                 state_d = RD0;
            end
         end
         RD0: begin
            MemAddress = w0;
            state_d    = span_q ? RD1 : (wr_q ? WR0 : DONE);
         end
         RD1: begin
            MemAddress = w1;
            state_d    = wr_q ? WR0 : DONE;
         end
         WR0: begin
            MemAddress = w0;
            MemDataWr  = merged[31:0];
            MemDMWr    = 1'b1;
            state_d    = span_q ? WR1 : DONE;
         end
         WR1: begin
            MemAddress = w1;
            MemDataWr  = merged[63:32];
            MemDMWr    = 1'b1;
            state_d    = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         err_q    <= 1'b0;
         datard_q <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == IDLE) && Req) err_q <= in_illegal;
         if (!wr_q && (((state_q == RD0) && !span_q) || (state_q == RD1))) begin
            datard_q <= lane_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if ((state_q == IDLE) && Req) begin
         addr_q  <= Address;
         wdata_q <= DataWr;
         wr_q    <= DMWr;
         ctrl_q  <= DMCtrl;
      end
      if (state_q == RD0) b0_q <= MemDataRd;
      if (state_q == RD1) b1_q <= MemDataRd;
   end

   assign DataRd    = datard_q;
   assign Busy      = (state_q != IDLE);
   assign Done      = (state_q == DONE);
   assign Error     = (state_q == DONE) && err_q;
   assign MemDMCtrl = F3_W;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential load/store unit between the execute stage and the data memory (`DataMemory`). Accepts one byte/half/word load or store request per transaction and issues only word-aligned, word-wide accesses to memory. Sub-word stores use read-modify-write; accesses that straddle a word boundary are split into two word accesses. Load results are returned little-endian, sign- or zero-extended.

## Interface
Parameters:
- `ALLOW_MISALIGNED`, default 1: 1 splits straddling accesses; 0 flags them as `Error`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `Req` input 1: request valid; accepted only when `Busy`=0.
- `Address` input 32: byte address of the request.
- `DataWr` input 32: store data, taken from the low bytes.
- `DMWr` input 1: 1 = store, 0 = load.
- `DMCtrl` input 3: funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `DataRd` output 32: extended load result; valid while `Done`=1 and held until the next accepted `Req`.
- `Busy` output 1: high whenever the FSM is not in IDLE.
- `Done` output 1: one-cycle completion pulse.
- `Error` output 1: qualifies `Done`; high for an illegal request.
- `MemAddress` output 32: word-aligned address to memory.
- `MemDataWr` output 32: merged word to memory.
- `MemDMWr` output 1: memory write enable; one cycle per written word.
- `MemDMCtrl` output 3: constant 3'b010.
- `MemDataRd` input 32: combinational read data from memory.

## Operation
- Request decode:
  - Byte offset `o` = `Address[1:0]`; size `n` = 1, 2 or 4.
  - Word 0 address W0 = `{Address[31:2],2'b00}`; W1 = W0+4, computed modulo 2^32 so 0xFFFFFFFC wraps to 0x00000000.
  - The access spans two words iff `o+n > 4`.
- FSM states and transitions:
  - IDLE → RD0 on an accepted load, or on a store that is not a full aligned word.
  - IDLE → WR0 on an aligned SW.
  - IDLE → DONE on an illegal request.
  - RD0 → RD1 if the access spans two words, else RD0 → WR0 (store) or DONE (load).
  - RD1 → WR0 (store) or DONE (load).
  - WR0 → WR1 if the access spans two words, else DONE.
  - WR1 → DONE.
  - DONE → IDLE.
- RD0/RD1: drive `MemAddress`=W0/W1; capture `MemDataRd` into word buffers B0/B1 at the end of the cycle.
- WR0/WR1: drive `MemAddress`=W0/W1 and `MemDataWr` = buffer with store bytes merged; `MemDMWr`=1.
  - Store byte k goes to overall byte offset o+k; offsets 0–3 land in B0, 4–7 in B1.
  - Aligned SW writes `DataWr` directly.
- Load extraction: take bytes o..o+n-1 from {B1,B0}, little-endian. Sign-extend for B/H, zero-extend for BU/HU/W.
- Illegal requests:
  - `DMCtrl` ∈ {011,110,111}, BU/HU with `DMWr`=1, or a straddling access with `ALLOW_MISALIGNED`=0.
  - Response: `Done`=`Error`=1, no memory write, `DataRd` unchanged.
- `Req` while `Busy`=1 is ignored; no queueing.
- Request fields are latched at acceptance; input changes afterwards have no effect.

## Timing
- Reset: state IDLE; `DataRd`=0, `Busy`=0, `Done`=0, `Error`=0, `MemAddress`=0, `MemDataWr`=0, `MemDMWr`=0. `MemDMCtrl` is always 3'b010.
- Latency, counted from the acceptance cycle (cycle 0) to the `Done` cycle:
  - Aligned SW: 2.
  - Load within one word: 2.
  - Straddling load: 3.
  - Sub-word store within one word: 3.
  - Straddling store: 5.
  - Illegal request: 1.
- Back-to-back: a new `Req` is accepted in the cycle after DONE at the earliest, since `Busy` is 0 in that cycle. `Req` is never accepted in the DONE cycle.
- `rst` mid-transaction: at the next edge return to IDLE with all outputs at reset values.
  - A completed WR0 of a straddling store is not rolled back.
  - No further memory write occurs after the reset edge.
- `MemDMWr` is never high outside WR0/WR1.

## Structure
- Package `lsu_pkg`:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - `lsu_state_t` enum (IDLE, RD0, RD1, WR0, WR1, DONE).
  - Size-decode function.
- Sub-module `lsu_lane` (combinational): byte-lane merge for stores and extract/extend for loads. Inputs: {B1,B0}, offset, size, signedness, store data.
- Top level holds the FSM, latched request and B0/B1 registers.

## Test plan
- Aligned SW @12 with `DataWr`=0x0000FFFC, then LW @12 → one write cycle to 12 with 0x0000FFFC; `DataRd`=0x0000FFFC; `Done` at cycles 2 and 2.
- Memory word @12 = 0x11223344; SB 0xAA @13 → RD0, then WR0 writes 0x1122AA44. LB @13 → 0xFFFFFFAA; LBU @13 → 0x000000AA.
- Words @0=0xDDCCBBAA, @4=0x44332211; LW @2 → 0x2211DDCC, `Done` at cycle 3. SH 0xBEEF @3 → writes @0=0xEFCCBBAA then @4=0x443322BE, `Done` at cycle 5.
- LW @0xFFFFFFFE → second access at `MemAddress`=0x00000000 (wrap).
- `DMCtrl`=3'b110, `ALLOW_MISALIGNED`=0 with LW @1, and SBU (`DMCtrl`=100, `DMWr`=1) → each `Done`=`Error`=1 at cycle 1, `MemDMWr` never high.
- Assert `rst` during WR0 of a straddling SW → IDLE next cycle, WR1 never issued. `Req` while `Busy` is ignored.
